// File: rtl/imm_extend_pipe_pkg.sv
// Shared types for the pipelined immediate extender: immediate kinds, skid states,
// RISC-V opcode constants and the opcode-to-immediate-type decoder.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_AUTO = 3'b111
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        imm_type_e typ;
        logic      illegal;
    } imm_res_t;

    function automatic imm_res_t decode_opcode(input logic [6:0] op);
        imm_res_t r;
        r.typ     = IMM_I;
        r.illegal = 1'b0;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_IMM_32, OP_SYSTEM: r.typ = IMM_I;
            OP_STORE:         r.typ = IMM_S;
            OP_BRANCH:        r.typ = IMM_B;
            OP_JAL:           r.typ = IMM_J;
            OP_LUI, OP_AUIPC: r.typ = IMM_U;
            default:          r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Bus between IF/ID, the immediate extender and ID/EX. Optional BTFN_PREDICT_EN adds
// the static-prediction fields carried with each entry.
interface imm_extend_pipe_if #(
    parameter int XLEN = 32
);
    // Both sides use valid/ready: a transfer happens on a rising clk edge where
    // valid & ready are high; valid and payload must stay stable until then.
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     Instr;
    logic [XLEN-1:0] PC;
    logic [2:0]      ImmSrc;
    logic            Flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ImmExtend;
    logic [2:0]      ImmType;
    logic            IllegalImm;
    logic [XLEN-1:0] PCOut;
`ifdef BTFN_PREDICT_EN
    logic            PredTaken;
    logic [XLEN-1:0] PredTarget;
`endif
    logic [1:0]      dbg_state;

    modport master (
        output in_valid, Instr, PC, ImmSrc, Flush, out_ready,
        input  in_ready, out_valid, ImmExtend, ImmType, IllegalImm, PCOut,
`ifdef BTFN_PREDICT_EN
        input  PredTaken, PredTarget,
`endif
        input  dbg_state
    );

    modport slave (
        input  in_valid, Instr, PC, ImmSrc, Flush, out_ready,
        output in_ready, out_valid, ImmExtend, ImmType, IllegalImm, PCOut,
`ifdef BTFN_PREDICT_EN
        output PredTaken, PredTarget,
`endif
        output dbg_state
    );

endinterface

// File: rtl/imm_extend_pipe_extract.sv
// Combinational immediate-type resolution and extraction; illegal selections
// yield a zero immediate with type I.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      imm_src_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       typ_o,
    output logic            illegal_o
);

    imm_res_t    res;
    logic [31:0] raw;

    always_comb begin
        res.typ     = IMM_I;
        res.illegal = 1'b0;
        case (imm_src_i)
            3'b000: res.typ = IMM_I;
            3'b001: res.typ = IMM_S;
            3'b010: res.typ = IMM_B;
            3'b011: res.typ = IMM_J;
            3'b100: res.typ = IMM_U;
            3'b111: begin
                if (AUTO_DECODE) res = decode_opcode(instr_i[6:0]);
                else             res.illegal = 1'b1;
            end
            default: res.illegal = 1'b1;
        endcase
    end

    // Every format is first assembled as a signed 32-bit value, then widened.
    always_comb begin
        raw = '0;
        case (res.typ)
            IMM_I:   raw = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_J:   raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            IMM_U:   raw = {instr_i[31:12], 12'b0};
            default: raw = '0;
        endcase
    end

    assign imm_o     = res.illegal ? '0 : XLEN'($signed(raw));
    assign typ_o     = res.illegal ? IMM_I : res.typ;
    assign illegal_o = res.illegal;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer (output + skid register).
// Define BTFN_PREDICT_EN to add registered backward-taken/forward-not-taken prediction.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    imm_extend_pipe_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       typ;
        logic            illegal;
        logic [XLEN-1:0] pc;
`ifdef BTFN_PREDICT_EN
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
`endif
    } entry_t;

    skid_state_e     state_q;
    entry_t          out_q;
    entry_t          skid_q;
    entry_t          entry_d;
    logic [XLEN-1:0] ext_imm;
    imm_type_e       ext_typ;
    logic            ext_illegal;
    logic            in_ready;
    logic            accept;

    imm_extract #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_extract (
        .instr_i   (bus.Instr),
        .imm_src_i (bus.ImmSrc),
        .imm_o     (ext_imm),
        .typ_o     (ext_typ),
        .illegal_o (ext_illegal)
    );

    always_comb begin
        entry_d         = '0;
        entry_d.imm     = ext_imm;
        entry_d.typ     = ext_typ;
        entry_d.illegal = ext_illegal;
        entry_d.pc      = bus.PC;
`ifdef BTFN_PREDICT_EN
        // Backward branches (negative offset) and all jumps predicted taken.
        entry_d.pred_taken  = !ext_illegal &&
                              ((ext_typ == IMM_J) || (ext_typ == IMM_B && ext_imm[XLEN-1]));
        entry_d.pred_target = bus.PC + ext_imm;
`endif
    end

    // in_ready comes only from registered state, so no out_ready -> in_ready path.
    assign in_ready = (state_q != ST_TWO);
    assign accept   = bus.in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (bus.Flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q   <= entry_d;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !bus.out_ready) begin
                        skid_q  <= entry_d;
                        state_q <= ST_TWO;
                    end else if (accept) begin
                        out_q   <= entry_d;
                    end else if (bus.out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (bus.out_ready) begin
                        out_q   <= skid_q;
                        state_q <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q != ST_EMPTY);
    assign bus.ImmExtend  = out_q.imm;
    assign bus.ImmType    = out_q.typ;
    assign bus.IllegalImm = out_q.illegal;
    assign bus.PCOut      = out_q.pc;
`ifdef BTFN_PREDICT_EN
    assign bus.PredTaken  = out_q.pred_taken;
    assign bus.PredTarget = out_q.pred_target;
`endif
    assign bus.dbg_state  = state_q;

endmodule
